// File: rtl/line_doubler_pkg.sv
// Shared constants and the rd_line replay decision for the line doubler.
package line_doubler_pkg;

  localparam int         LINE_LEN_DEF    = 768;
  localparam logic [7:0] DIM_MASK_RGB332 = 8'h5B;

  typedef enum logic [1:0] {
    RD_NEW_LINE,
    RD_REPLAY,
    RD_UNDERRUN
  } rd_action_t;

  // What an rd_line strobe does, given whether the newest complete line is
  // already the one being read and how often it has been replayed.
  function automatic rd_action_t rd_action(input logic       same_bank,
                                           input logic [2:0] rep_idx,
                                           input logic [2:0] rep_last);
    if (!same_bank)           return RD_NEW_LINE;
    else if (rep_idx < rep_last) return RD_REPLAY;
    else                      return RD_UNDERRUN;
  endfunction

endpackage

// File: rtl/line_doubler_dpram.sv
// Simple dual-port line RAM: one write port, one read port with a registered
// read (1-cycle latency). Contents are not reset.
module line_doubler_dpram #(
  parameter int DW = 8,
  parameter int AW = 11
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] q
);

  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) q <= mem[raddr];
  end

endmodule

// File: rtl/line_doubler.sv
// Ring-buffered scan doubler: lines are written at pixel rate into one bank
// and replayed at VGA rate from the previous bank, with optional dimming.
//
// rd_line action | meaning
// RD_NEW_LINE    | newest complete line differs from rd_bank: switch, rep_idx=0
// RD_REPLAY      | same line, replays left: rep_idx+1
// RD_UNDERRUN    | same line, replays exhausted: hold rep_idx, pulse underrun
module line_doubler
  import line_doubler_pkg::*;
#(
  parameter int            DW       = 8,
  parameter int            LINE_LEN = LINE_LEN_DEF,
  parameter int            NLINES   = 2,
  parameter int            REPEAT   = 2,
  parameter logic [DW-1:0] DIM_MASK = DIM_MASK_RGB332
) (
  input  logic                      clk24,
  input  logic                      reset_n,
  input  logic                      ce_wr,
  input  logic                      wr_line,
  input  logic [DW-1:0]             din,
  input  logic                      ce_rd,
  input  logic                      rd_line,
  input  logic                      scan_mode,
  output logic [DW-1:0]             dout,
  output logic                      dout_valid,
  output logic [2:0]                rep_idx,
  output logic                      overflow,
  output logic                      underrun,
  output logic [$clog2(NLINES)-1:0] wr_bank,
  output logic [$clog2(NLINES)-1:0] rd_bank
);

  localparam int BW = $clog2(NLINES);
  localparam int LA = $clog2(LINE_LEN);
  // Pointers must be able to hold LINE_LEN itself (the saturated value).
  localparam int CW = $clog2(LINE_LEN + 1);
  localparam logic [CW-1:0] LAST     = CW'(LINE_LEN);
  localparam logic [2:0]    REP_LAST = 3'(REPEAT - 1);

  logic [CW-1:0]    wr_addr, rd_addr;
  logic [BW-1:0]    wr_bank_nxt, newest_bank;
  logic             wr_full, ram_we, rd_fire;
  logic [BW+LA-1:0] ram_waddr, ram_raddr;
  logic [DW-1:0]    ram_q;
  logic             fire_d, past_end_d, dim_d;

  assign wr_bank_nxt = wr_bank + 1'b1;
  assign newest_bank = wr_bank - 1'b1;
  assign wr_full     = (wr_addr == LAST);
  assign ram_we      = ce_wr & (wr_line | ~wr_full);
  assign ram_waddr   = wr_line ? {wr_bank_nxt, {LA{1'b0}}} : {wr_bank, wr_addr[LA-1:0]};
  // rd_line restarts the line, so a coincident ce_rd is dropped.
  assign rd_fire     = ce_rd & ~rd_line;
  assign ram_raddr   = {rd_bank, rd_addr[LA-1:0]};

  line_doubler_dpram #(.DW(DW), .AW(BW + LA)) u_ram (
    .clk   (clk24),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (din),
    .re    (rd_fire),
    .raddr (ram_raddr),
    .q     (ram_q)
  );

  always_ff @(posedge clk24 or negedge reset_n) begin
    if (!reset_n) begin
      wr_bank  <= '0;
      wr_addr  <= '0;
      overflow <= 1'b0;
    end else if (wr_line) begin
      wr_bank  <= wr_bank_nxt;
      overflow <= 1'b0;
      wr_addr  <= ce_wr ? CW'(1) : '0;
    end else if (ce_wr) begin
      if (wr_full) overflow <= 1'b1;
      else         wr_addr  <= wr_addr + 1'b1;
    end
  end

  always_ff @(posedge clk24 or negedge reset_n) begin
    if (!reset_n) begin
      rd_bank  <= BW'(NLINES - 1);
      rd_addr  <= '0;
      rep_idx  <= '0;
      underrun <= 1'b0;
    end else begin
      underrun <= 1'b0;
      if (rd_line) begin
        rd_addr <= '0;
        case (rd_action(newest_bank == rd_bank, rep_idx, REP_LAST))
          RD_NEW_LINE: begin
            rd_bank <= newest_bank;
            rep_idx <= '0;
          end
          RD_REPLAY: rep_idx  <= rep_idx + 1'b1;
          default:   underrun <= 1'b1;
        endcase
      end else if (ce_rd && rd_addr != LAST) begin
        rd_addr <= rd_addr + 1'b1;
      end
    end
  end

  always_ff @(posedge clk24 or negedge reset_n) begin
    if (!reset_n) begin
      fire_d     <= 1'b0;
      past_end_d <= 1'b0;
      dim_d      <= 1'b0;
      dout       <= '0;
      dout_valid <= 1'b0;
    end else begin
      fire_d     <= rd_fire;
      past_end_d <= (rd_addr >= LAST);
      dim_d      <= scan_mode & rep_idx[0];
      if (fire_d) begin
        if (past_end_d) begin
          dout       <= '0;
          dout_valid <= 1'b0;
        end else begin
          dout       <= dim_d ? ((ram_q >> 1) & DIM_MASK) : ram_q;
          dout_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_line_doubler.sv
// Bench for line_doubler: directed scenarios with literal expectations plus
// randomized traffic, all checked every cycle against a behavioural model.
module tb_line_doubler;

  localparam int LL  = 768;
  localparam int NL  = 2;
  localparam int REP = 2;

  logic       clk24 = 1'b0, reset_n = 1'b0;
  logic       ce_wr = 1'b0, wr_line = 1'b0, ce_rd = 1'b0, rd_line = 1'b0, scan_mode = 1'b0;
  logic [7:0] din = '0;
  logic [7:0] dout;
  logic       dout_valid, overflow, underrun;
  logic [2:0] rep_idx;
  logic       wr_bank, rd_bank;

  line_doubler dut (
    .clk24(clk24), .reset_n(reset_n), .ce_wr(ce_wr), .wr_line(wr_line), .din(din),
    .ce_rd(ce_rd), .rd_line(rd_line), .scan_mode(scan_mode), .dout(dout),
    .dout_valid(dout_valid), .rep_idx(rep_idx), .overflow(overflow),
    .underrun(underrun), .wr_bank(wr_bank), .rd_bank(rd_bank)
  );

  always #20 clk24 = ~clk24;

  int n_cmp = 0, n_bad = 0, n_print = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [7:0] m_mem   [NL][LL];
  bit         m_known [NL][LL];
  int  m_wr_bank, m_wpos, m_rd_bank, m_rpos, m_rep;
  bit  m_ovf, e_underrun, e_valid, e_known, p_v, p_valid, p_known;
  logic [7:0] e_dout, p_dout;
  int  nb;

  // Halve each RGB332 channel independently.
  function automatic logic [7:0] dim(input logic [7:0] q);
    int r, g, b;
    r = int'(q[2:0]) / 2;
    g = int'(q[5:3]) / 2;
    b = int'(q[7:6]) / 2;
    return 8'((b << 6) | (g << 3) | r);
  endfunction

  always @(posedge clk24 or negedge reset_n) begin
    if (!reset_n) begin
      m_wr_bank = 0; m_wpos = 0; m_rd_bank = NL - 1; m_rpos = 0; m_rep = 0;
      m_ovf = 0; e_underrun = 0; e_valid = 0; e_dout = 0; e_known = 1; p_v = 0;
    end else begin
      if (p_v) begin
        e_dout = p_dout; e_valid = p_valid; e_known = p_known;
      end
      p_v = ce_rd && !rd_line;
      if (p_v) begin
        if (m_rpos >= LL) begin
          p_dout = 0; p_valid = 0; p_known = 1;
        end else begin
          p_dout  = (scan_mode && (m_rep % 2 == 1)) ? dim(m_mem[m_rd_bank][m_rpos])
                                                    : m_mem[m_rd_bank][m_rpos];
          p_valid = 1;
          p_known = m_known[m_rd_bank][m_rpos];
          m_rpos++;
        end
      end
      e_underrun = 0;
      if (rd_line) begin
        nb = (m_wr_bank + NL - 1) % NL;
        m_rpos = 0;
        if (nb != m_rd_bank) begin
          m_rd_bank = nb; m_rep = 0;
        end else if (m_rep < REP - 1) m_rep++;
        else e_underrun = 1;
      end
      if (wr_line) begin
        m_wr_bank = (m_wr_bank + 1) % NL; m_ovf = 0; m_wpos = 0;
      end
      if (ce_wr) begin
        if (m_wpos < LL) begin
          m_mem[m_wr_bank][m_wpos] = din;
          m_known[m_wr_bank][m_wpos] = 1;
          m_wpos++;
        end else m_ovf = 1;
      end
    end
  end

  always @(negedge clk24) begin
    if (reset_n) begin
      n_cmp++;
      if (dout_valid !== e_valid || (e_known && dout !== e_dout) ||
          int'(rep_idx) != m_rep || int'(rd_bank) != m_rd_bank ||
          int'(wr_bank) != m_wr_bank || overflow !== m_ovf || underrun !== e_underrun) begin
        n_bad++;
        if (n_print < 20)
          $display("FAIL model t=%0t dout %h/%h valid %b/%b rep %0d/%0d rd_bank %0d/%0d wr_bank %0d/%0d ovf %b/%b underrun %b/%b",
                   $time, dout, e_dout, dout_valid, e_valid, rep_idx, m_rep, rd_bank, m_rd_bank,
                   wr_bank, m_wr_bank, overflow, m_ovf, underrun, e_underrun);
        n_print++;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input bit w_line, input bit w_ce, input logic [7:0] d,
                     input bit r_line, input bit r_ce);
    @(negedge clk24);
    wr_line = w_line; ce_wr = w_ce; din = d; rd_line = r_line; ce_rd = r_ce;
  endtask

  task automatic wdrv(input bit w_line, input bit w_ce, input logic [7:0] d);
    @(negedge clk24);
    wr_line = w_line; ce_wr = w_ce; din = d;
  endtask

  task automatic rdrv(input bit r_line, input bit r_ce);
    @(negedge clk24);
    rd_line = r_line; ce_rd = r_ce;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(0, 0, 8'h00, 0, 0);
  endtask

  logic [7:0] w767;
  logic [7:0] rv;

  initial begin
    repeat (3) @(negedge clk24);
    #5 reset_n = 1'b1;
    check("rst_rd_bank", rd_bank, 1);
    check("rst_wr_bank", wr_bank, 0);
    check("rst_dout", {dout_valid, dout, rep_idx, overflow, underrun}, 0);

    // Line of address pattern into bank 1, then make it the read line.
    cyc(1, 0, 8'h00, 0, 0);
    cyc(0, 0, 8'h00, 1, 0);
    for (int i = 0; i < LL; i++) cyc(0, 1, 8'(i), 0, 0);
    cyc(1, 0, 8'h00, 0, 0);
    cyc(0, 0, 8'h00, 1, 0);
    idle(1);
    check("t1_rd_bank", rd_bank, 1);
    check("t1_rep_idx", rep_idx, 0);
    for (int i = 0; i < 10; i++) cyc(0, 0, 8'h00, 0, 1);
    idle(2);
    check("t1_dout9", {dout_valid, dout}, {1'b1, 8'd9});
    for (int i = 10; i < LL; i++) cyc(0, 0, 8'h00, 0, 1);
    idle(2);
    check("t1_dout767", {dout_valid, dout}, {1'b1, 8'hFF});
    cyc(0, 0, 8'h00, 0, 1);
    idle(2);
    check("t1_past_end", {dout_valid, dout}, 0);

    // Short all-white line, replayed with scanline dimming.
    for (int i = 0; i < 4; i++) cyc(0, 1, 8'hFF, 0, 0);
    cyc(1, 0, 8'h00, 0, 0);
    cyc(0, 0, 8'h00, 1, 0);
    cyc(0, 0, 8'h00, 1, 0);
    idle(1);
    check("t2_rep_idx", rep_idx, 1);
    scan_mode = 1'b1;
    cyc(0, 0, 8'h00, 0, 1);
    idle(2);
    check("t2_dim", {dout_valid, dout}, {1'b1, 8'h5B});
    cyc(0, 0, 8'h00, 1, 0);
    idle(1);
    check("t2_underrun", {underrun, rep_idx}, {1'b1, 3'd1});
    idle(1);
    check("t2_underrun_end", underrun, 0);
    scan_mode = 1'b0;

    // Overlong source line.
    cyc(1, 0, 8'h00, 0, 0);
    for (int i = 0; i < 800; i++) begin
      rv = 8'($urandom);
      if (i == 767) w767 = rv;
      cyc(0, 1, rv, 0, 0);
      if (i == 768) check("t3_ovf_at_768", overflow, 0);
      if (i == 769) check("t3_ovf_after", overflow, 1);
    end
    cyc(1, 0, 8'h00, 0, 0);
    idle(1);
    check("t3_ovf_clear", overflow, 0);
    cyc(0, 0, 8'h00, 1, 0);
    for (int i = 0; i < LL; i++) cyc(0, 0, 8'h00, 0, 1);
    idle(2);
    check("t3_last_cell", dout, w767);

    // Coincident strobes.
    cyc(1, 0, 8'h00, 1, 0);
    idle(1);
    check("t4_banks", {rd_bank, wr_bank}, 2'b00);
    cyc(1, 1, 8'hA5, 0, 0);
    cyc(0, 1, 8'h3C, 0, 0);
    cyc(1, 0, 8'h00, 0, 0);
    cyc(0, 0, 8'h00, 1, 0);
    cyc(0, 0, 8'h00, 0, 1);
    idle(2);
    check("t4_addr0", dout, 8'hA5);
    cyc(0, 0, 8'h00, 0, 1);
    idle(2);
    check("t4_addr1", dout, 8'h3C);

    // Reset in the middle of a read: bank 1 still holds the address pattern
    // beyond its first two cells.
    cyc(0, 0, 8'h00, 1, 0);
    for (int i = 0; i < 300; i++) cyc(0, 0, 8'h00, 0, 1);
    idle(2);
    check("t5_pre_reset", dout, 8'd43);
    cyc(0, 0, 8'h00, 0, 1);
    #2 reset_n = 1'b0;
    #1 check("t5_async_reset", {dout_valid, dout, rd_bank, wr_bank}, {1'b0, 8'h00, 1'b1, 1'b0});
    idle(2);
    #5 reset_n = 1'b1;

    // Randomized concurrent traffic.
    fork
      begin
        repeat (14) begin
          wdrv(1, 1'($urandom), 8'($urandom));
          repeat ($urandom_range(1, 60)) wdrv(0, ($urandom % 4) != 0, 8'($urandom));
        end
        wdrv(0, 0, 8'h00);
      end
      begin
        repeat (30) begin
          @(negedge clk24);
          scan_mode = 1'($urandom);
          rd_line = 1'b1; ce_rd = 1'b0;
          repeat ($urandom_range(1, 40)) rdrv(0, 1'($urandom));
        end
        rdrv(0, 0);
      end
    join
    idle(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
